// File: rtl/toy_phy_reg_alloc_ctrl_pkg.sv
// Shared sizes and FSM state type for the physical-register free-list
// allocator (one instance each for the int and fp register files).
package toy_phy_reg_alloc_ctrl_pkg;
  localparam int PHY_REG_NUM      = 64;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int INST_DECODE_NUM  = 4;
  localparam int ARCH_REG_NUM     = 32;

  typedef enum logic [1:0] {
    ALLOC_NORMAL  = 2'd0,
    ALLOC_FLUSH   = 2'd1,
    ALLOC_RECOVER = 2'd2
  } alloc_state_e;
endpackage

// File: rtl/toy_phy_reg_alloc_ctrl_if.sv
// Allocator <-> rename/commit bus. master = rename/commit side,
// slave = allocator.
interface toy_phy_reg_alloc_ctrl_if #(
  parameter int PHY_REG_NUM      = toy_phy_reg_alloc_ctrl_pkg::PHY_REG_NUM,
  parameter int PHY_REG_ID_WIDTH = toy_phy_reg_alloc_ctrl_pkg::PHY_REG_ID_WIDTH,
  parameter int ALLOC_NUM        = toy_phy_reg_alloc_ctrl_pkg::INST_DECODE_NUM
);
  logic [ALLOC_NUM-1:0]                       v_alloc_rdy;
  logic [ALLOC_NUM-1:0]                       v_alloc_vld;
  logic [ALLOC_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_alloc_id;
  logic [PHY_REG_NUM-1:0]                     v_release;
  logic                                       cancel_en;
  logic [PHY_REG_NUM-1:0]                     v_backup_busy;
  logic [PHY_REG_ID_WIDTH:0]                  free_cnt;
  logic                                       recover_busy;
  logic                                       err_double_free;

  modport master (
    output v_alloc_rdy, v_release, cancel_en, v_backup_busy,
    input  v_alloc_vld, v_alloc_id, free_cnt, recover_busy, err_double_free
  );

  modport slave (
    input  v_alloc_rdy, v_release, cancel_en, v_backup_busy,
    output v_alloc_vld, v_alloc_id, free_cnt, recover_busy, err_double_free
  );
endinterface

// File: rtl/toy_phy_reg_pick.sv
// Find-first-N-set over a free bitmap. Slot k (in index order) takes the
// lowest still-unclaimed set bit if it requests one.
module toy_phy_reg_pick #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int IW = 6
) (
  input  logic [W-1:0]         map,
  input  logic [N-1:0]         req,
  output logic [N-1:0][IW-1:0] id,
  output logic [N-1:0]         found,
  output logic [W-1:0]         picked
);
  logic [W-1:0] rem;
  logic [W-1:0] low;

  // Walk slots in order, peeling the lowest remaining set bit each time
  always_comb begin
    rem    = map;
    low    = '0;
    id     = '0;
    found  = '0;
    picked = '0;
    for (int k = 0; k < N; k++) begin
      low = rem & (~rem + W'(1));
      if (req[k] && (|rem)) begin
        found[k] = 1'b1;
        picked   = picked | low;
        rem      = rem & ~low;
        for (int b = 0; b < W; b++)
          if (low[b]) id[k] = IW'(b);
      end
    end
  end
endmodule

// File: rtl/toy_phy_reg_alloc_ctrl.sv
// Physical register free-list controller: keeps a free bitmap, pre-picks
// up to ALLOC_NUM IDs into per-slot output registers (vld/rdy), takes
// commit releases back, and rebuilds from the committed busy map on cancel.
// Optional macro TOY_ALLOC_DOUBLE_FREE_CHK_EN adds a sticky double-free flag.
module toy_phy_reg_alloc_ctrl #(
  parameter int PHY_REG_NUM      = toy_phy_reg_alloc_ctrl_pkg::PHY_REG_NUM,
  parameter int PHY_REG_ID_WIDTH = toy_phy_reg_alloc_ctrl_pkg::PHY_REG_ID_WIDTH,
  parameter int ALLOC_NUM        = toy_phy_reg_alloc_ctrl_pkg::INST_DECODE_NUM,
  parameter int ARCH_REG_NUM     = toy_phy_reg_alloc_ctrl_pkg::ARCH_REG_NUM
) (
  input  logic                    clk,
  input  logic                    rst_n,  // active-high despite the name
  toy_phy_reg_alloc_ctrl_if.slave bus
);
  import toy_phy_reg_alloc_ctrl_pkg::*;

  localparam int CW = PHY_REG_ID_WIDTH + 1;
  localparam logic [PHY_REG_NUM-1:0] RST_FREE_MAP =
    {{(PHY_REG_NUM-ARCH_REG_NUM){1'b1}}, {ARCH_REG_NUM{1'b0}}};
  localparam logic [CW-1:0] RST_FREE_CNT = CW'(PHY_REG_NUM - ARCH_REG_NUM);

  alloc_state_e state_q, state_d;
  logic [PHY_REG_NUM-1:0]                     free_map_q, free_map_d;
  logic [ALLOC_NUM-1:0]                       vld_q, vld_d;
  logic [ALLOC_NUM-1:0][PHY_REG_ID_WIDTH-1:0] id_q, id_d;
  logic [CW-1:0]                              free_cnt_q, free_cnt_d;
  logic                                       recover_busy;

  logic [ALLOC_NUM-1:0]                       fire, refill, req;
  logic                                       refill_en;
  logic [ALLOC_NUM-1:0][PHY_REG_ID_WIDTH-1:0] pick_id;
  logic [ALLOC_NUM-1:0]                       pick_found;
  logic [PHY_REG_NUM-1:0]                     picked;

  assign fire   = vld_q & bus.v_alloc_rdy;
  assign refill = ~vld_q | fire;
  // Refill on every edge whose next state is NORMAL. That includes the
  // RECOVER->NORMAL edge, so fresh IDs are already valid in the first NORMAL
  // cycle (cancel+3) while nothing is shown during FLUSH/RECOVER.
  assign refill_en = (state_d == ALLOC_NORMAL);
  assign req       = refill & {ALLOC_NUM{refill_en}};

  toy_phy_reg_pick #(
    .N  (ALLOC_NUM),
    .W  (PHY_REG_NUM),
    .IW (PHY_REG_ID_WIDTH)
  ) u_pick (
    .map    (free_map_q),
    .req    (req),
    .id     (pick_id),
    .found  (pick_found),
    .picked (picked)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ALLOC_NORMAL;
    else       state_q <= state_d;
  end

  // FSM next state: cancel always (re)enters FLUSH
  always_comb begin
    state_d = state_q;
    if (bus.cancel_en) begin
      state_d = ALLOC_FLUSH;
    end else begin
      case (state_q)
        ALLOC_FLUSH:   state_d = ALLOC_RECOVER;
        ALLOC_RECOVER: state_d = ALLOC_NORMAL;
        default:       state_d = ALLOC_NORMAL;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    recover_busy = (state_q != ALLOC_NORMAL);
  end

  // Next free map / slot contents / free count
  always_comb begin
    free_map_d = (free_map_q & ~picked) | bus.v_release;
    vld_d      = vld_q & ~fire;
    id_d       = id_q;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      if (pick_found[i]) begin
        vld_d[i] = 1'b1;
        id_d[i]  = pick_id[i];
      end
    end
    // Cancel wins: slot contents are dropped, pool rebuilt from commit state
    if (bus.cancel_en) begin
      free_map_d = ~bus.v_backup_busy | bus.v_release;
      vld_d      = '0;
      id_d       = '0;
    end
    free_cnt_d = '0;
    for (int b = 0; b < PHY_REG_NUM; b++)
      free_cnt_d = free_cnt_d + CW'(free_map_d[b]);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      free_map_q <= RST_FREE_MAP;
      vld_q      <= '0;
      id_q       <= '0;
      free_cnt_q <= RST_FREE_CNT;
    end else begin
      free_map_q <= free_map_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign bus.v_alloc_vld  = vld_q;
  assign bus.v_alloc_id   = id_q;
  assign bus.free_cnt     = free_cnt_q;
  assign bus.recover_busy = recover_busy;

`ifdef TOY_ALLOC_DOUBLE_FREE_CHK_EN
  logic [PHY_REG_NUM-1:0] held_map;
  logic                   dbl_hit;
  logic                   err_q, err_d;

  // IDs currently parked in a valid slot
  always_comb begin
    held_map = '0;
    for (int i = 0; i < ALLOC_NUM; i++)
      if (vld_q[i]) held_map[id_q[i]] = 1'b1;
  end

  assign dbl_hit = |(bus.v_release & (free_map_q | held_map));
  assign err_d   = err_q | dbl_hit;

  // Sticky double-free flag, cleared only by reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  a_no_double_free: assert property (@(posedge clk) disable iff (rst_n) !dbl_hit);

  assign bus.err_double_free = err_q;
`else
  assign bus.err_double_free = 1'b0;
`endif
endmodule
